// File: rtl/bf16_accum_if.sv
// rtl/bf16_accum_if.sv - product-beat input and result output bundle for bf16_accum
interface bf16_accum_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] in_data_i;
  logic        in_last_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] out_data_o;
  logic        out_nan_o;
  logic        out_inf_o;
  logic        busy_o;

  modport slave (
    input  in_valid_i, in_data_i, in_last_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_nan_o, out_inf_o, busy_o
  );

  modport master (
    output in_valid_i, in_data_i, in_last_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_nan_o, out_inf_o, busy_o
  );
endinterface

// File: rtl/bf16_accum.sv
// rtl/bf16_accum.sv - bfloat16 dot-product accumulator, one beat per 3 cycles, RNE, flush-to-zero
module bf16_accum (
  input logic         clk_i,
  input logic         rst_i,
  bf16_accum_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ALIGN, NORM, OUT} state_t;
  state_t state, state_nx;

  logic [15:0] acc;
  logic        nan_sticky;
  logic [15:0] beat;
  logic        last_q;

  logic        al_pass, al_pass_nan, al_sign, al_sub;
  logic [15:0] al_pass_val;
  logic [7:0]  al_exp;
  logic [10:0] al_big, al_small;

  // Operand decode and alignment: the larger magnitude is always the minuend.
  logic [7:0]  a_exp, b_exp, a_sig, b_sig, big_exp, small_exp, small_sig, exp_diff;
  logic [14:0] a_mag, b_mag;
  logic        b_big, a_inf, b_inf, b_nan;
  logic [10:0] big_aln, small_ext, small_shr, small_lost, small_aln;

  assign a_exp     = acc[14:7];
  assign b_exp     = beat[14:7];
  assign a_sig     = (a_exp == 8'd0) ? 8'd0 : {1'b1, acc[6:0]};
  assign b_sig     = (b_exp == 8'd0) ? 8'd0 : {1'b1, beat[6:0]};
  assign a_mag     = (a_exp == 8'd0) ? 15'd0 : acc[14:0];
  assign b_mag     = (b_exp == 8'd0) ? 15'd0 : beat[14:0];
  assign a_inf     = (a_exp == 8'hFF);
  assign b_inf     = (b_exp == 8'hFF) && (beat[6:0] == 7'd0);
  assign b_nan     = (b_exp == 8'hFF) && (beat[6:0] != 7'd0);
  assign b_big     = (b_mag > a_mag);
  assign big_exp   = b_big ? b_exp : a_exp;
  assign small_exp = b_big ? a_exp : b_exp;
  assign small_sig = b_big ? a_sig : b_sig;
  assign exp_diff  = big_exp - small_exp;
  assign big_aln   = {(b_big ? b_sig : a_sig), 3'b000};
  assign small_ext = {small_sig, 3'b000};
  assign small_shr = small_ext >> exp_diff[3:0];
  assign small_lost = small_ext & ~(11'h7FF << exp_diff[3:0]);
  assign small_aln = (exp_diff >= 8'd11) ? {10'd0, |small_sig}
                                         : (small_shr | {10'd0, |small_lost});

  logic        pass_take, pass_nan;
  logic [15:0] pass_val;

  always_comb begin
    pass_take = 1'b0;
    pass_nan  = 1'b0;
    pass_val  = acc;
    if (nan_sticky) begin
      pass_take = 1'b1;
    end else if (b_nan || (a_inf && b_inf && (acc[15] != beat[15]))) begin
      pass_take = 1'b1;
      pass_nan  = 1'b1;
      pass_val  = 16'h7FC0;
    end else if (a_inf) begin
      pass_take = 1'b1;
    end else if (b_inf) begin
      pass_take = 1'b1;
      pass_val  = beat;
    end
  end

  logic [11:0]       sum;
  logic [3:0]        lz;
  logic [10:0]       nrm;
  logic signed [9:0] nrm_exp, rnd_exp;
  logic [8:0]        rnd_sig;
  logic              rnd_up;
  logic [15:0]       norm_res;

  always_comb begin
    sum = al_sub ? ({1'b0, al_big} - {1'b0, al_small}) : ({1'b0, al_big} + {1'b0, al_small});
    lz  = 4'd0;
    for (int i = 0; i <= 10; i++) begin
      if (sum[i]) lz = 4'(10 - i);
    end
    if (sum[11]) begin
      nrm     = {sum[11:2], sum[1] | sum[0]};
      nrm_exp = $signed({2'b00, al_exp}) + 10'sd1;
    end else begin
      nrm     = sum[10:0] << lz;
      nrm_exp = $signed({2'b00, al_exp}) - $signed({6'd0, lz});
    end
    // Round to nearest even on guard with round|sticky as the tie breaker.
    rnd_up  = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
    rnd_sig = {1'b0, nrm[10:3]} + {8'd0, rnd_up};
    rnd_exp = rnd_sig[8] ? (nrm_exp + 10'sd1) : nrm_exp;
    if ((sum == 12'd0) || (rnd_exp <= 10'sd0)) begin
      norm_res = 16'h0000;
    end else if (rnd_exp > 10'sd254) begin
      norm_res = {al_sign, 15'h7F80};
    end else begin
      norm_res = {al_sign, rnd_exp[7:0], rnd_sig[6:0]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    bus.in_ready_o  = 1'b0;
    bus.out_valid_o = 1'b0;
    bus.busy_o      = 1'b1;
    case (state)
      IDLE: begin
        bus.in_ready_o = 1'b1;
        bus.busy_o     = 1'b0;
        if (bus.in_valid_i) state_nx = ALIGN;
      end
      ALIGN: state_nx = NORM;
      NORM:  state_nx = last_q ? OUT : IDLE;
      OUT: begin
        bus.out_valid_o = 1'b1;
        if (bus.out_ready_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc         <= 16'h0000;
      nan_sticky  <= 1'b0;
      beat        <= 16'h0000;
      last_q      <= 1'b0;
      al_pass     <= 1'b0;
      al_pass_nan <= 1'b0;
      al_pass_val <= 16'h0000;
      al_sign     <= 1'b0;
      al_sub      <= 1'b0;
      al_exp      <= 8'd0;
      al_big      <= 11'd0;
      al_small    <= 11'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid_i) begin
            beat   <= bus.in_data_i;
            last_q <= bus.in_last_i;
          end
        end
        ALIGN: begin
          al_pass     <= pass_take;
          al_pass_nan <= pass_nan;
          al_pass_val <= pass_val;
          al_sign     <= b_big ? beat[15] : acc[15];
          al_sub      <= acc[15] ^ beat[15];
          al_exp      <= big_exp;
          al_big      <= big_aln;
          al_small    <= small_aln;
        end
        NORM: begin
          if (al_pass) begin
            acc <= al_pass_val;
            if (al_pass_nan) nan_sticky <= 1'b1;
          end else begin
            acc <= norm_res;
          end
        end
        OUT: begin
          if (bus.out_ready_i) begin
            acc        <= 16'h0000;
            nan_sticky <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_data_o = acc;
  assign bus.out_nan_o  = nan_sticky;
  assign bus.out_inf_o  = (acc[14:0] == 15'h7F80);

endmodule

// File: tb/tb_bf16_accum.sv
// tb/tb_bf16_accum.sv - directed and randomized checks of bf16_accum against an exact-arithmetic model
module tb_bf16_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  bf16_accum_if bus ();

  bf16_accum u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Exact sum of two finite bf16 values as scaled integers, then RNE back to bf16.
  function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b);
    int     ea, eb, base, p, sh, e;
    longint va, vb, total, mag, q, rem, half;
    logic   s;
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    if (ea == 0 && eb == 0) return 16'h0000;
    if (ea == 0) return b;
    if (eb == 0) return a;
    if (ea - eb > 40) return a;
    if (eb - ea > 40) return b;
    base = (ea < eb) ? ea : eb;
    va = longint'({1'b1, a[6:0]}) <<< (ea - base);
    vb = longint'({1'b1, b[6:0]}) <<< (eb - base);
    if (a[15]) va = -va;
    if (b[15]) vb = -vb;
    total = va + vb;
    if (total == 0) return 16'h0000;
    s   = (total < 0);
    mag = s ? -total : total;
    p = 0;
    for (int i = 0; i < 63; i++) if (mag[i]) p = i;
    if (p > 7) begin
      sh   = p - 7;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == 256) begin
        q  = 128;
        sh = sh + 1;
      end
    end else begin
      sh = p - 7;
      q  = mag << (7 - p);
    end
    e = base + sh;
    if (e > 254) return s ? 16'hFF80 : 16'h7F80;
    if (e <= 0) return 16'h0000;
    return {s, e[7:0], q[6:0]};
  endfunction

  task automatic send_beat(input logic [15:0] data, input logic last);
    int k = 0;
    while (!bus.in_ready_o && k < 20) begin
      tick();
      k++;
    end
    if (!bus.in_ready_o) check("in_ready_timeout", 32'(bus.in_ready_o), 32'd1);
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = data;
    bus.in_last_i  = last;
    tick();
    bus.in_valid_i = 1'b0;
    bus.in_last_i  = 1'b0;
  endtask

  // Called right after the accept edge of a last beat.
  task automatic take_result(input string tag, input logic [15:0] exp_data, input logic exp_nan,
                             input logic exp_inf, input int hold, input logic chk_lat);
    int k = 1;
    while (!bus.out_valid_o && k < 10) begin
      tick();
      k++;
    end
    if (chk_lat) check({tag, "_latency"}, 32'(k), 32'd3);
    check({tag, "_valid"}, 32'(bus.out_valid_o), 32'd1);
    check({tag, "_data"},  32'(bus.out_data_o),  32'(exp_data));
    check({tag, "_nan"},   32'(bus.out_nan_o),   32'(exp_nan));
    check({tag, "_inf"},   32'(bus.out_inf_o),   32'(exp_inf));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(bus.out_valid_o), 32'd1);
      check({tag, "_hold_data"},  32'(bus.out_data_o),  32'(exp_data));
      check({tag, "_hold_ready"}, 32'(bus.in_ready_o),  32'd0);
    end
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    check({tag, "_idle_busy"},  32'(bus.busy_o),     32'd0);
    check({tag, "_idle_ready"}, 32'(bus.in_ready_o), 32'd1);
  endtask

  task automatic dot2(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] exp_data, input logic exp_nan, input logic exp_inf,
                      input int hold);
    send_beat(a, 1'b0);
    send_beat(b, 1'b1);
    take_result(tag, exp_data, exp_nan, exp_inf, hold, 1'b1);
  endtask

  initial begin
    logic [15:0] model_acc, beat;
    int          len, sel, seen;

    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = 16'h0000;
    bus.in_last_i   = 1'b0;
    bus.out_ready_i = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check("rst_in_ready",  32'(bus.in_ready_o),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_busy",      32'(bus.busy_o),      32'd0);
    check("rst_out_data",  32'(bus.out_data_o),  32'h0000);
    check("rst_out_nan",   32'(bus.out_nan_o),   32'd0);
    check("rst_out_inf",   32'(bus.out_inf_o),   32'd0);

    dot2("one_plus_one",   16'h3F80, 16'h3F80, 16'h4000, 1'b0, 1'b0, 0);
    dot2("cancel",         16'h3F80, 16'hBF80, 16'h0000, 1'b0, 1'b0, 0);
    dot2("inf_minus_inf",  16'h7F80, 16'hFF80, 16'h7FC0, 1'b1, 1'b0, 0);
    dot2("overflow",       16'h7F7F, 16'h7F7F, 16'h7F80, 1'b0, 1'b1, 0);
    dot2("tie_even_down",  16'h3F80, 16'h3B80, 16'h3F80, 1'b0, 1'b0, 0);
    dot2("tie_even_up",    16'h3F81, 16'h3B80, 16'h3F82, 1'b0, 1'b0, 0);
    dot2("nan_sticky",     16'h7FC1, 16'h4000, 16'h7FC0, 1'b1, 1'b0, 0);
    send_beat(16'h3F80, 1'b1);
    take_result("after_nan", 16'h3F80, 1'b0, 1'b0, 0, 1'b1);
    dot2("inf_plus_fin",   16'hFF80, 16'h4000, 16'hFF80, 1'b0, 1'b1, 0);
    dot2("flush_operand",  16'h0055, 16'h4040, 16'h4040, 1'b0, 1'b0, 0);
    dot2("far_apart",      16'h4000, 16'h3A80, 16'h4000, 1'b0, 1'b0, 0);
    dot2("hold_5",         16'h3F80, 16'h3F80, 16'h4000, 1'b0, 1'b0, 5);

    // Reset while the last beat is in NORM must drop the result silently.
    send_beat(16'h3F80, 1'b0);
    send_beat(16'h4000, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid_o) seen++;
      tick();
    end
    check("rst_norm_no_valid", 32'(seen),             32'd0);
    check("rst_norm_acc",      32'(bus.out_data_o),   32'h0000);
    check("rst_norm_idle",     32'(bus.in_ready_o),   32'd1);

    for (int t = 0; t < 40; t++) begin
      len = int'($urandom_range(1, 5));
      model_acc = 16'h0000;
      for (int j = 0; j < len; j++) begin
        sel = int'($urandom_range(0, 9));
        if (sel == 0) begin
          beat = {1'($urandom_range(0, 1)), 8'd0, 7'($urandom_range(0, 127))};
        end else if (sel == 1 && model_acc[14:7] != 8'd0) begin
          beat = model_acc ^ 16'h8000;
        end else if (sel == 2 && model_acc[14:7] != 8'd0 && model_acc[6:0] != 7'h7F) begin
          beat = {~model_acc[15], model_acc[14:0] + 15'd1};
        end else begin
          beat = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 140)), 7'($urandom_range(0, 127))};
        end
        model_acc = model_add(model_acc, beat);
        send_beat(beat, (j == len - 1));
      end
      take_result($sformatf("rand%0d", t), model_acc, 1'b0, (model_acc[14:0] == 15'h7F80),
                  int'($urandom_range(0, 2)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bf16_accum.md
BF16_ACCUM -- requirements
Module: bf16_accum

Interface
REQ-001 SHALL have parameter none; all widths are fixed for bfloat16 (1 sign, 8 exponent, 7 fraction).
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 in_valid_i  input  1  product beat valid (driven by the bf16 multiplier stage).
REQ-005 in_ready_o  output  1  accumulator can accept a beat.
REQ-006 in_data_i  input  16  bf16 product operand.
REQ-007 in_last_i  input  1  beat is the final term of the current dot product.
REQ-008 out_valid_o  output  1  accumulated result valid.
REQ-009 out_ready_i  input  1  consumer accepts the result.
REQ-010 out_data_o  output  16  bf16 accumulated sum.
REQ-011 out_nan_o / out_inf_o  output  1 each  result is NaN / infinite; valid with out_valid_o.
REQ-012 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states: IDLE, ALIGN, NORM, OUT.
- IDLE: in_ready_o=1; on in_valid_i&in_ready_o, latch in_data_i and in_last_i, then go to ALIGN.
- ALIGN: compare exponents; right-shift the smaller significand (hidden 1 restored) into an 8+3 bit field with guard/round/sticky; go to NORM.
- NORM: add or subtract significands, normalise, round, write the accumulator register; if last then OUT, else IDLE.
- OUT: out_valid_o=1; on out_ready_i, clear the accumulator to +0 and the NaN-sticky flag, then go to IDLE.
REQ-014 in_ready_o SHALL be 0 in ALIGN, NORM and OUT; throughput is one beat per 3 cycles; out_valid_o rises 3 cycles after the accept edge of the last beat.
REQ-015 out_data_o, out_nan_o and out_inf_o SHALL remain stable while out_valid_o=1 and out_ready_i=0.
REQ-016 Rounding SHALL be round-to-nearest-even using guard, round and sticky bits; a rounding carry-out SHALL increment the exponent.
REQ-017 Operands and results with exponent 0 SHALL be treated as zero (flush-to-zero); the sign of a flushed result SHALL be +.
REQ-018 Exact cancellation SHALL yield +0 (0x0000).
REQ-019 A result exponent greater than 254 after rounding SHALL yield signed Inf (0x7F80 or 0xFF80).
REQ-020 A NaN operand (exp=255, frac≠0) or Inf+(-Inf) SHALL set the NaN-sticky flag; while the flag is set, the accumulator holds 0x7FC0 and later beats are ignored.
REQ-021 Inf + finite SHALL give the Inf; Inf + same-sign Inf SHALL give the Inf.
REQ-022 An exponent difference of 11 or more SHALL collapse the smaller operand into the sticky bit only.
REQ-023 out_inf_o = (out_data_o[14:0]==0x7F80); out_nan_o = NaN-sticky flag.

Reset
REQ-024 On rst_i=1: state=IDLE, accumulator=0x0000, NaN-sticky=0, out_valid_o=0, out_data_o=0x0000, out_nan_o=0, out_inf_o=0, busy_o=0; in_ready_o=1 in the first cycle after reset.
REQ-025 Reset asserted mid-operation (ALIGN, NORM or OUT) SHALL discard the in-flight beat and any pending result without producing an output handshake.

Verification
REQ-026 Beats 0x3F80, then 0x3F80 with last -> out_data_o=0x4000, nan=0, inf=0, out_valid_o 3 cycles after the last accept.
REQ-027 Beats 0x3F80, then 0xBF80 with last -> 0x0000; beats 0x7F80, then 0xFF80 with last -> 0x7FC0, out_nan_o=1.
REQ-028 Beats 0x7F7F, then 0x7F7F with last -> 0x7F80, out_inf_o=1; beats 0x3F80, then 0x3B80 with last (tie) -> 0x3F80; beats 0x3F81, then 0x3B80 with last -> 0x3F82.
REQ-029 Beat 0x7FC1 followed by 0x4000 with last -> 0x7FC0; a following beat 0x3F80 with last -> 0x3F80 (sticky flag and accumulator cleared by the output handshake).
REQ-030 Hold out_ready_i=0 for 5 cycles -> out_valid_o and out_data_o held, in_ready_o=0; out_ready_i=1 -> IDLE on the next cycle.
REQ-031 Assert rst_i during NORM of a last beat -> no out_valid_o pulse; accumulator=0x0000.
